// File: rtl/part_cmd_engine.sv
// Part-tester command processor: decodes host bytes and drives the part's pins, scan chain and gated clock.
// Response bytes wait for tx_ready; received bytes arriving in non-listening states are dropped.
module part_cmd_engine #(
  parameter int          NPIS    = 14,
  parameter int          NPOS    = 11,
  parameter int          NREGS   = 19,
  parameter int          RST_CYC = 16,
  parameter logic [7:0]  ACK_CHR = "K",
  parameter logic [7:0]  ERR_CHR = "E"
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  input  logic            tx_ready,
  output logic [NPIS-1:0] pis_o,
  input  logic [NPOS-1:0] pos_i,
  output logic            part_rstn_o,
  output logic            part_clk_en,
  output logic            scan_en,
  output logic            scan_in,
  input  logic            scan_out,
  output logic            idle,
  output logic            err
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_RX, S_SHIFT, S_SEND,
    S_WAIT_TX, S_RUN, S_FREE, S_PRST, S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_cmd;
  logic [15:0]     r_len;
  logic [15:0]     r_cnt;
  logic            r_bit;
  logic            r_tx_start;
  logic [7:0]      r_tx_data;
  logic [NPIS-1:0] r_pis;
  logic            r_err;
  logic [1:0]      r_phase;

  logic            w_is_bit;
  logic            w_last;
  logic [15:0]     w_len_lo;
  logic            w_tx_done;
  logic            w_pos_bit;
  logic [7:0]      w_send_chr;
  logic [7:0]      w_resp_chr;
  logic            w_err_set;

  // The chain length is supplied by the host at run time.
  if (NREGS < 1) begin : g_nregs_invalid
  end

  assign w_is_bit  = (rx_data == "0") || (rx_data == "1");
  assign w_last    = (r_cnt == r_len - 16'd1);
  assign w_len_lo  = {r_len[15:8], rx_data};
  // Phase 2 is only reached after tx_ready was seen low, so high here is its rising edge.
  assign w_tx_done = (r_phase == 2'd2) && tx_ready;

  always_comb begin
    w_pos_bit = 1'b0;
    for (int i = 0; i < NPOS; i++) begin
      if (r_cnt == 16'(i)) w_pos_bit = pos_i[i];
    end
  end

  assign w_send_chr = (r_cmd == "g") ? {7'h18, scan_out} : {7'h18, w_pos_bit};

  always_comb begin
    w_next      = r_state;
    w_resp_chr  = ACK_CHR;
    w_err_set   = 1'b0;
    part_clk_en = 1'b0;
    scan_en     = 1'b0;
    scan_in     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            "r":                     w_next = S_PRST;
            "s", "g", "e", "i", "o": w_next = S_LEN_HI;
            "f":                     w_next = S_FREE;
            default: begin
              w_next     = S_RESP;
              w_resp_chr = ERR_CHR;
              w_err_set  = 1'b1;
            end
          endcase
        end
      end
      S_LEN_HI: if (rx_valid) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (rx_valid) begin
          if (w_len_lo == 16'd0)                  w_next = S_RESP;
          else if (r_cmd == "s" || r_cmd == "e")  w_next = S_DATA_RX;
          else if (r_cmd == "g" || r_cmd == "i")  w_next = S_SEND;
          else                                    w_next = S_RUN;
        end
      end
      S_DATA_RX: begin
        if (rx_valid) begin
          if (!w_is_bit) begin
            w_next     = S_RESP;
            w_resp_chr = ERR_CHR;
            w_err_set  = 1'b1;
          end else if (r_cmd == "s") begin
            w_next = S_SHIFT;
          end else if (w_last) begin
            w_next = S_RESP;
          end
        end
      end
      S_SHIFT: begin
        part_clk_en = 1'b1;
        scan_en     = 1'b1;
        scan_in     = (r_cmd == "s") && r_bit;
        if (w_last)            w_next = S_RESP;
        else if (r_cmd == "g") w_next = S_SEND;
        else                   w_next = S_DATA_RX;
      end
      S_SEND: w_next = S_WAIT_TX;
      S_WAIT_TX: begin
        if (w_tx_done) begin
          if (r_cmd == "g")  w_next = S_SHIFT;
          else if (w_last)   w_next = S_RESP;
          else               w_next = S_SEND;
        end
      end
      S_RUN: begin
        part_clk_en = 1'b1;
        if (w_last) w_next = S_RESP;
      end
      S_FREE: begin
        part_clk_en = 1'b1;
        if (rx_valid && rx_data == "d") w_next = S_RESP;
      end
      S_PRST: if (r_cnt == 16'(RST_CYC - 1)) w_next = S_RESP;
      S_RESP: if (w_tx_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cmd      <= 8'd0;
      r_len      <= 16'd0;
      r_cnt      <= 16'd0;
      r_bit      <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'd0;
      r_pis      <= '0;
      r_err      <= 1'b0;
      r_phase    <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_err_set) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 16'd0;
          if (rx_valid) r_cmd <= rx_data;
        end
        S_LEN_HI: if (rx_valid) r_len[15:8] <= rx_data;
        S_LEN_LO: begin
          if (rx_valid) begin
            r_len[7:0] <= rx_data;
            r_cnt      <= 16'd0;
          end
        end
        S_DATA_RX: begin
          if (rx_valid && w_is_bit) begin
            r_bit <= rx_data[0];
            if (r_cmd == "e") begin
              for (int i = 0; i < NPIS; i++) begin
                if (r_cnt == 16'(i)) r_pis[i] <= rx_data[0];
              end
              if (!w_last) r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        S_SHIFT: if (!w_last) r_cnt <= r_cnt + 16'd1;
        S_SEND:  r_tx_data <= w_send_chr;
        S_RUN:   r_cnt <= r_cnt + 16'd1;
        S_PRST: begin
          r_cnt <= r_cnt + 16'd1;
          r_pis <= '0;
          r_err <= 1'b0;
        end
        default: ;
      endcase
      if (r_state == S_WAIT_TX || r_state == S_RESP) begin
        case (r_phase)
          2'd0: if (tx_ready) begin
            r_tx_start <= 1'b1;
            r_phase    <= 2'd1;
          end
          2'd1: if (!tx_ready) begin
            r_tx_start <= 1'b0;
            r_phase    <= 2'd2;
          end
          default: ;
        endcase
        if (r_state == S_WAIT_TX && w_tx_done && r_cmd == "i" && !w_last)
          r_cnt <= r_cnt + 16'd1;
      end
      if (w_next != r_state) r_phase <= 2'd0;
      if (w_next == S_RESP && r_state != S_RESP) r_tx_data <= w_resp_chr;
    end
  end

  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign pis_o       = r_pis;
  assign err         = r_err;
  assign idle        = (r_state == S_IDLE);
  assign part_rstn_o = (r_state != S_PRST);

endmodule

// File: tb/tb_part_cmd_engine.sv
// Bench for part_cmd_engine: byte-level uart_tx responder, scan-chain part model and expected-byte scoreboard.
module tb_part_cmd_engine;
  localparam int NPIS = 14;
  localparam int NPOS = 11;
  localparam int NREGS = 19;

  logic            clk = 1'b0;
  logic            rst;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_ready = 1'b1;
  logic [NPIS-1:0] pis_o;
  logic [NPOS-1:0] pos_i;
  logic            part_rstn_o, part_clk_en, scan_en, scan_in, scan_out, idle, err;

  part_cmd_engine dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready),
    .pis_o(pis_o), .pos_i(pos_i), .part_rstn_o(part_rstn_o),
    .part_clk_en(part_clk_en), .scan_en(scan_en), .scan_in(scan_in),
    .scan_out(scan_out), .idle(idle), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_rx_cyc = 0;
  always @(posedge clk) cyc++;

  // Part model: scan flops shift only on an enabled clock with scan enable.
  logic [NREGS-1:0] chain = '0;
  always @(posedge clk) if (part_clk_en && scan_en) chain <= {chain[NREGS-2:0], scan_in};
  assign scan_out = chain[NREGS-1];

  int   clk_pulses = 0, se_pulses = 0, runs = 0, rstn_low = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (part_clk_en === 1'b1) begin
      clk_pulses++;
      if (prev_en !== 1'b1) runs++;
    end
    if (scan_en === 1'b1) se_pulses++;
    if (part_rstn_o === 1'b0) rstn_low++;
    prev_en = part_clk_en;
  end

  // uart_tx responder and byte scoreboard.
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] exp_b;
  int         tx_busy = 0;
  always @(negedge clk) begin
    if (tx_busy > 0) begin
      tx_busy--;
      if (tx_busy == 0) tx_ready = 1'b1;
    end else if (tx_ready && tx_start === 1'b1) begin
      cap_q.push_back(tx_data);
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: got %02h, no byte expected", tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (tx_data !== exp_b) begin
          n_fail++;
          $display("FAIL tx_byte: got %02h expected %02h", tx_data, exp_b);
        end
      end
      tx_ready = 1'b0;
      tx_busy  = 5;
    end
  end

  function automatic logic [7:0] asc(input logic b);
    return b ? 8'h31 : 8'h30;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    last_rx_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [15:0] len);
    send_byte(c, 3);
    send_byte(len[15:8], 3);
    send_byte(len[7:0], 3);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (!(idle === 1'b1 && tx_busy == 0) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done"}, 32'(k < 5000), 32'd1);
    check({name, "_all_sent"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  int          b_pulses, b_se, b_runs, b_rstn, f_cyc, k;
  logic [18:0] p = 19'h5A3C6;
  logic [31:0] got;

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; pos_i = '0;
    repeat (3) @(negedge clk);
    check("rst_idle", idle, 1);
    check("rst_pis", pis_o, 0);
    check("rst_rstn", part_rstn_o, 1);
    check("rst_clk_en", part_clk_en, 0);
    check("rst_scan_en", scan_en, 0);
    check("rst_scan_in", scan_in, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // 'i': one ASCII byte per primary output, bit 0 first.
    pos_i = 11'b000_1010_1001;
    cap_q.delete();
    for (int i = 0; i < NPOS; i++) exp_q.push_back(asc(pos_i[i]));
    exp_q.push_back("K");
    send_cmd("i", 16'd11);
    wait_idle("i");
    check("i_count", cap_q.size(), 12);
    got = 0;
    for (int i = 0; i < 11 && i < cap_q.size(); i++) got = {got[30:0], cap_q[i][0]};
    check("i_literal", got, 32'h4A8);

    exp_q.push_back("K");
    send_cmd("e", 16'd3);
    send_byte("1", 3); send_byte("0", 3); send_byte("1", 3);
    wait_idle("e3");
    check("e3_pis", pis_o, 14'h0005);

    exp_q.push_back("K");
    send_cmd("e", 16'd20);
    for (int i = 0; i < 20; i++) send_byte("1", 3);
    wait_idle("e20");
    check("e20_pis", pis_o, 14'h3FFF);

    // 's' loads p first-bit-first; 'g' must return it in the same order.
    b_pulses = clk_pulses; b_se = se_pulses;
    exp_q.push_back("K");
    send_cmd("s", 16'd19);
    for (int i = 0; i < 19; i++) send_byte(asc(p[18-i]), 3);
    wait_idle("s");
    check("s_pulses", clk_pulses - b_pulses, 19);
    check("s_scan_en", se_pulses - b_se, 19);
    check("s_chain", chain, 32'h5A3C6);

    b_pulses = clk_pulses; b_se = se_pulses;
    for (int i = 0; i < 19; i++) exp_q.push_back(asc(p[18-i]));
    exp_q.push_back("K");
    send_cmd("g", 16'd19);
    wait_idle("g");
    check("g_pulses", clk_pulses - b_pulses, 19);
    check("g_scan_en", se_pulses - b_se, 19);
    check("g_chain", chain, 0);

    b_pulses = clk_pulses; b_se = se_pulses; b_runs = runs;
    exp_q.push_back("K");
    send_cmd("o", 16'd10);
    wait_idle("o10");
    check("o10_pulses", clk_pulses - b_pulses, 10);
    check("o10_runs", runs - b_runs, 1);
    check("o10_scan_en", se_pulses - b_se, 0);

    b_pulses = clk_pulses;
    exp_q.push_back("K");
    send_cmd("o", 16'd0);
    wait_idle("o0");
    check("o0_pulses", clk_pulses - b_pulses, 0);

    // 'f': enabled from the cycle after 'f' through the cycle carrying 'd'.
    b_pulses = clk_pulses; b_runs = runs;
    exp_q.push_back("K");
    send_byte("f", 3);
    f_cyc = last_rx_cyc;
    repeat (40) @(negedge clk);
    send_byte("x", 3);
    send_byte("d", 0);
    check("f_pulses", clk_pulses - b_pulses, last_rx_cyc - f_cyc);
    check("f_last_cycle", part_clk_en, 0);
    wait_idle("f");
    check("f_runs", runs - b_runs, 1);
    check("f_total", clk_pulses - b_pulses, 50);

    exp_q.push_back("E");
    send_byte("z", 3);
    wait_idle("z");
    check("z_err", err, 1);

    exp_q.push_back("E");
    send_cmd("e", 16'd2);
    send_byte("1", 3); send_byte("q", 3);
    wait_idle("eq");
    check("eq_pis", pis_o, 14'h3FFF);
    check("eq_err", err, 1);

    b_rstn = rstn_low;
    exp_q.push_back("K");
    send_byte("r", 3);
    wait_idle("r");
    check("r_low_cycles", rstn_low - b_rstn, 16);
    check("r_err", err, 0);
    check("r_pis", pis_o, 0);

    // Reset during 'g' while the first byte is being handed to uart_tx.
    exp_q.push_back(asc(chain[NREGS-1]));
    send_byte("g", 3);
    send_byte(8'h00, 3);
    send_byte(8'h05, 0);
    k = 0;
    while (tx_start !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("g_rst_tx_seen", 32'(k < 50), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("g_rst_idle", idle, 1);
    check("g_rst_tx_start", tx_start, 0);
    repeat (40) @(negedge clk);
    check("g_rst_quiet_idle", idle, 1);
    check("g_rst_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/part_cmd_engine.md
Name: part_cmd_engine

Overview:
Synthesizable command processor inside part_tester. It sits between uart_rx/uart_tx and the pins of the part under test. It decodes the single-byte ASCII command set (r, s, g, e, i, o, f, d), a 16-bit big-endian length or cycle count, and ASCII '0'/'1' data bytes. It drives the part's primary inputs, its scan chain and its gated clock. It generalises the fixed CSOC command processor:
- pin and register counts are parameters;
- every command is acknowledged;
- malformed input is reported.

Parameters:
NPIS, 14, number of part primary inputs driven (pis_o width)
NPOS, 11, number of part primary outputs sampled (pos_i width)
NREGS, 19, scan-chain length; informational only, the host supplies the length
RST_CYC, 16, cycles part_rstn_o is held low by the 'r' command
ACK_CHR, "K", byte sent on successful command completion
ERR_CHR, "E", byte sent on error

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_valid  in  1  one-cycle pulse: rx_data holds a new byte (uart_rx rcv)
rx_data  in  8  received byte
tx_start  out  1  request to uart_tx; held until tx_ready is seen low
tx_data  out  8  byte to send; stable while tx_start=1
tx_ready  in  1  uart_tx idle flag (high = idle)
pis_o  out  NPIS  part primary inputs
pos_i  in  NPOS  part primary outputs
part_rstn_o  out  1  part active-low reset
part_clk_en  out  1  part clock enable; one high cycle = one part clock
scan_en  out  1  part scan enable (test_se)
scan_in  out  1  scan chain serial input
scan_out  in  1  scan chain serial output
idle  out  1  high in IDLE
err  out  1  sticky error flag

Behaviour:
- Reset (rst=1 at a clk edge) values: state=IDLE, pis_o=0, part_rstn_o=1, part_clk_en=0, scan_en=0, scan_in=0, tx_start=0, tx_data=0, err=0. Reset mid-command aborts immediately; nothing is transmitted.
- States: IDLE, LEN_HI, LEN_LO, DATA_RX, SHIFT, SEND, WAIT_TX, RUN, FREE, PRST, RESP.
- IDLE, on rx_valid:
  - 'r' -> PRST.
  - 's', 'g', 'e', 'i', 'o' -> LEN_HI.
  - 'f' -> FREE.
  - Any other byte -> RESP with ERR_CHR; err:=1.
- LEN_HI, then LEN_LO: each latches one byte of 16-bit len (hi first); cnt:=0. After LEN_LO:
  - len==0 -> RESP with ACK_CHR (all commands).
  - 's', 'e' -> DATA_RX.
  - 'g', 'i' -> SEND.
  - 'o' -> RUN.
- DATA_RX: wait for rx_valid.
  - Byte '0'/'1' gives bit b.
  - 'e': pis_o[cnt]:=b if cnt<NPIS, otherwise the bit is discarded.
  - 's': SHIFT.
  - Any other byte: RESP with ERR_CHR, err:=1, no pin change.
  - After the last bit (cnt==len-1) -> RESP with ACK_CHR.
- SHIFT: one cycle with scan_en=1, scan_in=b, part_clk_en=1. Then returns to DATA_RX, or RESP when it was the last bit.
- SEND ('i' and 'g'):
  - 'i': tx_data = "1"/"0" of pos_i[cnt]; cnt>=NPOS sends "0".
  - 'g': tx_data = ASCII of scan_out sampled at state entry. After the byte, one shift cycle (scan_en=1, scan_in=0, part_clk_en=1).
  - Bytes are sent in order of cnt: 0 first.
- WAIT_TX handshake:
  - tx_start:=1 only when tx_ready=1.
  - Drop tx_start on the first cycle tx_ready=0.
  - The byte is complete on the next tx_ready rising edge. Next byte or RESP follows.
- RUN: part_clk_en=1 for exactly len consecutive cycles, with scan_en=0. Then RESP with ACK_CHR.
- FREE: part_clk_en=1 every cycle until rx_valid with 'd'; part_clk_en is 0 from the following cycle. Other bytes are ignored. Then RESP with ACK_CHR.
- PRST: pis_o:=0, part_rstn_o=0 for RST_CYC cycles, err:=0. Then RESP with ACK_CHR.
- RESP: send one byte via the WAIT_TX handshake, then IDLE.
- rx_valid outside IDLE, LEN_*, DATA_RX and FREE is dropped, not queued.
- Counters: cnt and the run counter are 16-bit; len=65535 must not wrap early.
- pis_o changes only in DATA_RX ('e') and PRST. It holds its value at all other times.

Test Plan:
- rst released, 'i', 0x00, 0x0B, with pos_i=11'b000_1010_1001 -> tx gives eleven bytes "1","0","0","1","0","1","0","1","0","0","0", then "K".
- 'e', 0x00, 0x03, "1","0","1" -> pis_o[2:0]=3'b101, all other bits 0, tx "K". Then 'e', len 20, all "1" -> pis_o=14'h3FFF, then "K".
- 's', len 19, pattern p, on a 19-bit shift-register model -> 19 part_clk_en pulses with scan_en=1, then "K". Then 'g', len 19 -> returns p in shift-out order, then "K".
- 'o', 0x00, 0x0A -> exactly 10 contiguous part_clk_en cycles, then "K". 'o', 0x00, 0x00 -> zero pulses, then "K".
- 'f', 40 idle cycles, then 'd' -> part_clk_en high from the cycle after 'f' through the cycle of 'd', then "K". An 'x' byte during FREE has no effect.
- 'z' -> "E" and err=1. 'e', len 2, "1", "q" -> "E" with pis_o unchanged. 'r' -> part_rstn_o low 16 cycles, err=0, pis_o=0, then "K". rst asserted mid-'g' -> idle=1 next cycle, tx_start=0.
